// File: rtl/moore_pattern_pkg.sv
// Shared types and helpers for the moore_pattern_tx serial stimulus transmitter.
// Holds the FSM state encoding, default widths and the frame-length clamp.
package moore_pattern_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        SEND = 2'b01,
        DONE = 2'b11
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_LEN_W = 4;
    localparam int DEF_DIV_W = 4;
    localparam int DEF_CNT_W = 4;

    // A length of zero, or anything longer than the pattern register, means "whole pattern".
    function automatic int unsigned clamp_len(input int unsigned len, input int unsigned width);
        return (len == 0 || len > width) ? width : len;
    endfunction

endpackage

// File: rtl/moore_pattern_tx_bit_tick_gen.sv
// Bit-period timer: tick marks the last clock of each (div+1)-clock bit period.
// The count is held at zero while disabled, so every enable rise starts a fresh period.
module bit_tick_gen
    import moore_pattern_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] cnt_d;

    always_comb begin
        tick  = enable && (cnt_q == div);
        cnt_d = cnt_q + DIV_W'(1);
        if (!enable || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/moore_pattern_tx.sv
// Serial pattern transmitter: captures a frame on start and shifts it out on x,
// one bit per (div+1) clocks, repeating the frame repeat_n extra times back to back.
module moore_pattern_tx
    import moore_pattern_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LEN_W = DEF_LEN_W,
    parameter int DIV_W = DEF_DIV_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [DIV_W-1:0] div,
    input  logic [CNT_W-1:0] repeat_n,
    input  logic             msb_first,
    output logic             x,
    output logic             ready,
    output logic             busy,
    output logic             done
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pat_q, pat_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] rep_q, rep_d;
    logic             msb_q, msb_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic             x_q, x_d;
    logic [LEN_W-1:0] len_eff_in;
    logic             tick;

    assign len_eff_in = LEN_W'(clamp_len(32'(len), 32'(WIDTH)));

    // Bit sent at frame position idx; shifting avoids an index wider than the pattern.
    function automatic logic frame_bit(input logic [WIDTH-1:0] pat,
                                       input logic [LEN_W-1:0] flen,
                                       input logic             msb,
                                       input logic [LEN_W-1:0] idx);
        logic [LEN_W-1:0] pos;
        logic [WIDTH-1:0] shifted;
        pos     = msb ? (flen - idx - LEN_W'(1)) : idx;
        shifted = pat >> pos;
        return shifted[0];
    endfunction

    bit_tick_gen #(
        .DIV_W (DIV_W)
    ) u_tick (
        .clock  (clock),
        .reset  (reset),
        .enable (state_q == SEND),
        .div    (div_q),
        .tick   (tick)
    );

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        len_d   = len_q;
        div_d   = div_q;
        rep_d   = rep_q;
        msb_d   = msb_q;
        idx_d   = idx_q;
        x_d     = x_q;
        case (state_q)
            IDLE: begin
                x_d   = 1'b0;
                idx_d = '0;
                if (start) begin
                    pat_d   = pattern;
                    len_d   = len_eff_in;
                    div_d   = div;
                    rep_d   = repeat_n;
                    msb_d   = msb_first;
                    x_d     = frame_bit(pattern, len_eff_in, msb_first, '0);
                    state_d = SEND;
                end
            end
            SEND: begin
                if (tick) begin
                    if (idx_q == len_q - LEN_W'(1)) begin
                        idx_d = '0;
                        if (rep_q != '0) begin
                            rep_d = rep_q - CNT_W'(1);
                            x_d   = frame_bit(pat_q, len_q, msb_q, '0);
                        end else begin
                            x_d     = 1'b0;
                            state_d = DONE;
                        end
                    end else begin
                        idx_d = idx_q + LEN_W'(1);
                        x_d   = frame_bit(pat_q, len_q, msb_q, idx_q + LEN_W'(1));
                    end
                end
            end
            DONE: begin
                x_d     = 1'b0;
                state_d = IDLE;
            end
            default: begin
                x_d     = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            div_q   <= '0;
            rep_q   <= '0;
            msb_q   <= 1'b0;
            idx_q   <= '0;
            x_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            div_q   <= div_d;
            rep_q   <= rep_d;
            msb_q   <= msb_d;
            idx_q   <= idx_d;
            x_q     <= x_d;
        end
    end

    assign x     = x_q;
    assign ready = (state_q == IDLE);
    assign busy  = (state_q == SEND);
    assign done  = (state_q == DONE);

endmodule

// File: tb/tb_moore_pattern_tx.sv
// Self-checking bench for moore_pattern_tx: a queue-based model of the serial stream
// checked every cycle, plus hand-computed bit sequences for the directed scenarios.
module tb_moore_pattern_tx;

    localparam int WIDTH = 8;
    localparam int LEN_W = 4;
    localparam int DIV_W = 4;
    localparam int CNT_W = 4;

    logic             clock;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] pattern;
    logic [LEN_W-1:0] len;
    logic [DIV_W-1:0] div;
    logic [CNT_W-1:0] repeat_n;
    logic             msb_first;
    logic             x;
    logic             ready;
    logic             busy;
    logic             done;

    int pass_cnt  = 0;
    int total_cnt = 0;

    moore_pattern_tx #(
        .WIDTH (WIDTH),
        .LEN_W (LEN_W),
        .DIV_W (DIV_W),
        .CNT_W (CNT_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .pattern   (pattern),
        .len       (len),
        .div       (div),
        .repeat_n  (repeat_n),
        .msb_first (msb_first),
        .x         (x),
        .ready     (ready),
        .busy      (busy),
        .done      (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Model: the whole expected x stream of a transmission is queued, one entry per SEND cycle.
    logic mdl_q[$];
    logic mdl_done  = 1'b0;
    logic mdl_valid = 1'b0;

    always @(posedge clock) begin
        if (reset) begin
            mdl_q.delete();
            mdl_done  = 1'b0;
            mdl_valid = 1'b1;
        end else if (mdl_q.size() > 0) begin
            void'(mdl_q.pop_front());
            if (mdl_q.size() == 0) mdl_done = 1'b1;
        end else if (mdl_done) begin
            mdl_done = 1'b0;
        end else if (start) begin
            int le;
            le = (len == 0 || int'(len) > WIDTH) ? WIDTH : int'(len);
            for (int r = 0; r <= int'(repeat_n); r++) begin
                for (int b = 0; b < le; b++) begin
                    int pos;
                    pos = msb_first ? (le - 1 - b) : b;
                    for (int d = 0; d <= int'(div); d++) mdl_q.push_back(pattern[pos]);
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (mdl_valid) begin
            logic mx, mr, mb, md;
            mb = (mdl_q.size() > 0);
            mx = mb ? mdl_q[0] : 1'b0;
            md = !mb && mdl_done;
            mr = !mb && !mdl_done;
            checkOutput("model_xrbd", 16'({x, ready, busy, done}), 16'({mx, mr, mb, md}));
        end
    end

    task automatic applyStimulus(input logic [WIDTH-1:0] p, input logic [LEN_W-1:0] l,
                                 input logic [DIV_W-1:0] d, input logic [CNT_W-1:0] r,
                                 input logic m);
        @(negedge clock);
        pattern   = p;
        len       = l;
        div       = d;
        repeat_n  = r;
        msb_first = m;
        start     = 1'b1;
        @(negedge clock);
        start     = 1'b0;
    endtask

    // Samples x n times, step cycles apart; first sample ends up as the most significant bit.
    task automatic collect_bits(input int n, input int step, output logic [15:0] acc);
        acc = '0;
        for (int i = 0; i < n; i++) begin
            acc = {acc[14:0], x};
            repeat (step) @(negedge clock);
        end
    endtask

    task automatic check_tail(input string name);
        checkOutput({name, "_done"}, 16'(done), 16'd1);
        @(negedge clock);
        checkOutput({name, "_ready"}, 16'(ready), 16'd1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] bits;
        reset     = 1'b1;
        start     = 1'b0;
        pattern   = '0;
        len       = '0;
        div       = '0;
        repeat_n  = '0;
        msb_first = 1'b0;
        repeat (3) @(negedge clock);
        checkOutput("reset_state", 16'({x, ready, busy, done}), 16'b0100);
        reset = 1'b0;
        @(negedge clock);

        $display("[TB] basic MSB-first frame");
        applyStimulus(8'b1011_0010, 4'd8, 4'd0, 4'd0, 1'b1);
        collect_bits(8, 1, bits);
        checkOutput("t1_bits", bits, 16'b1011_0010);
        check_tail("t1");

        $display("[TB] bit-period divider");
        applyStimulus(8'b1011_0010, 4'd8, 4'd2, 4'd0, 1'b1);
        collect_bits(8, 3, bits);
        checkOutput("t2_bits", bits, 16'b1011_0010);
        check_tail("t2");

        $display("[TB] LSB-first with repeats");
        applyStimulus(8'h05, 4'd3, 4'd0, 4'd2, 1'b0);
        collect_bits(9, 1, bits);
        checkOutput("t3_bits", bits, 16'b1_0110_1101);
        check_tail("t3");

        $display("[TB] length clamping");
        applyStimulus(8'b1011_0010, 4'd0, 4'd0, 4'd0, 1'b1);
        collect_bits(8, 1, bits);
        checkOutput("t4_len0_bits", bits, 16'b1011_0010);
        check_tail("t4_len0");
        applyStimulus(8'h96, 4'd12, 4'd1, 4'd0, 1'b0);
        collect_bits(8, 2, bits);
        checkOutput("t4_len12_bits", bits, 16'b0110_1001);
        check_tail("t4_len12");

        $display("[TB] ignored inputs while busy");
        applyStimulus(8'b1011_0010, 4'd8, 4'd1, 4'd0, 1'b1);
        pattern = 8'hFF;
        div     = 4'd0;
        start   = 1'b1;
        collect_bits(8, 2, bits);
        checkOutput("t5_bits", bits, 16'b1011_0010);
        checkOutput("t5_done", 16'(done), 16'd1);
        start = 1'b0;
        @(negedge clock);
        checkOutput("t5_ready", 16'(ready), 16'd1);

        $display("[TB] reset mid-frame");
        applyStimulus(8'b1011_0010, 4'd8, 4'd0, 4'd1, 1'b1);
        repeat (4) @(negedge clock);
        checkOutput("t6_bit4", 16'({x, busy}), 16'b01);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        checkOutput("t6_after_reset", 16'({x, ready, busy, done}), 16'b0100);
        @(negedge clock);
        checkOutput("t6_no_done", 16'({ready, done}), 16'b10);
        applyStimulus(8'b1011_0010, 4'd8, 4'd0, 4'd0, 1'b1);
        collect_bits(8, 1, bits);
        checkOutput("t6_restart_bits", bits, 16'b1011_0010);
        check_tail("t6");

        repeat (2) @(negedge clock);
        $display("[TB] %0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
